// File: rtl/ariane_pkg.sv
// Decoded-instruction types passed from the decoder to the issue stage.
// Includes the per-slot record used by the ID/issue queue.
package ariane_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_imm;
  } scoreboard_entry_t;

  // One queue slot: the decoded instruction plus its control-flow tag
  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } issue_slot_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record shared across the CVA6 front end.
// Only the fields this slice needs are present.
package config_pkg;

  typedef struct packed {
    int unsigned xlen;
    logic        rvc;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/id_issue_queue_pkg.sv
// Sizing helpers for the ID/issue queue.
package id_issue_queue_pkg;

  // A one-slot queue still needs a one-bit pointer
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_issue_queue.sv
// Circular buffer of decoded instructions between decode and issue, with an
// optional cap on the number of control-flow entries held at once.
module id_issue_queue
  import ariane_pkg::*;
  import id_issue_queue_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DEPTH    = 2,
  parameter int unsigned           CF_LIMIT = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_i,
  input  logic                       is_ctrl_flow_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output scoreboard_entry_t          issue_entry_o,
  output logic                       issue_entry_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  issue_slot_t      mem_reg [DEPTH];
  logic [DEPTH-1:0] slot_we;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next, cf_count_reg, cf_count_next;
  logic             head_valid, pop, push, space_ok, cf_ok;
  issue_slot_t      head;
  logic             cfg_unused;

  assign cfg_unused = ^CVA6Cfg;

  assign head       = mem_reg[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign pop        = issue_instr_ack_i && head_valid;
  assign space_ok   = (32'(count_reg) < DEPTH) || pop;

  generate
    if (CF_LIMIT != 0) begin : g_cf_limit
      // Retiring a control-flow head frees its budget for a same-cycle push
      assign cf_ok = !is_ctrl_flow_i || (32'(cf_count_reg) < CF_LIMIT)
                     || (pop && head.is_ctrl_flow);
    end else begin : g_cf_free
      assign cf_ok = 1'b1;
    end
  endgenerate

  assign ready_o = space_ok && cf_ok;
  assign push    = valid_i && ready_o && !flush_i;

  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    cf_count_next = cf_count_reg;
    if (flush_i) begin
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
      cf_count_next = '0;
    end else begin
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      case ({push && is_ctrl_flow_i, pop && head.is_ctrl_flow})
        2'b10:   cf_count_next = cf_count_reg + CNT_W'(1);
        2'b01:   cf_count_next = cf_count_reg - CNT_W'(1);
        default: cf_count_next = cf_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      cf_count_reg <= '0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      cf_count_reg <= cf_count_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Payload is never reset; it is only observed while the head is valid
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_we[i]) begin
        mem_reg[i] <= '{sbe: decoded_i, is_ctrl_flow: is_ctrl_flow_i};
      end
    end
  end

  assign issue_entry_o       = head.sbe;
  assign issue_entry_valid_o = head_valid;
  assign is_ctrl_flow_o      = head_valid && head.is_ctrl_flow;
  assign usage_o             = count_reg;

endmodule

// File: tb/tb_id_issue_queue.sv
// Three queue configurations driven with common stimulus and checked every
// cycle against a queue-based reference model of the acceptance rules.
module tb_id_issue_queue;
  import ariane_pkg::*;

  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0, valid = 1'b0, cf_in = 1'b0, ack = 1'b0;
  scoreboard_entry_t din = '0;
  logic              rdy [N];
  logic              vld [N];
  logic              cfo [N];
  scoreboard_entry_t head [N];
  logic [2:0]        use0, use1;
  logic [0:0]        use2;

  typedef struct packed {
    logic              cf;
    scoreboard_entry_t e;
  } mdl_t;

  mdl_t mq [N][$];
  int   total = 0;
  int   bad = 0;
  int   seq = 0;

  always #5 clk = ~clk;

  id_issue_queue #(.DEPTH(4), .CF_LIMIT(0)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_i(din),
    .is_ctrl_flow_i(cf_in), .valid_i(valid), .ready_o(rdy[0]),
    .issue_entry_o(head[0]), .issue_entry_valid_o(vld[0]),
    .is_ctrl_flow_o(cfo[0]), .issue_instr_ack_i(ack), .usage_o(use0));

  id_issue_queue #(.DEPTH(4), .CF_LIMIT(1)) u_cf (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_i(din),
    .is_ctrl_flow_i(cf_in), .valid_i(valid), .ready_o(rdy[1]),
    .issue_entry_o(head[1]), .issue_entry_valid_o(vld[1]),
    .is_ctrl_flow_o(cfo[1]), .issue_instr_ack_i(ack), .usage_o(use1));

  id_issue_queue #(.DEPTH(1), .CF_LIMIT(0)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .decoded_i(din),
    .is_ctrl_flow_i(cf_in), .valid_i(valid), .ready_o(rdy[2]),
    .issue_entry_o(head[2]), .issue_entry_valid_o(vld[2]),
    .is_ctrl_flow_o(cfo[2]), .issue_instr_ack_i(ack), .usage_o(use2));

  function automatic int dep(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int cfl(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic logic [63:0] usage_of(int i);
    case (i)
      0:       return 64'(use0);
      1:       return 64'(use1);
      default: return 64'(use2);
    endcase
  endfunction

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pop(int i);
    return ack && (mq[i].size() != 0);
  endfunction

  function automatic bit m_ready(int i);
    int  ncf = 0;
    bit  space, cfok;
    for (int k = 0; k < mq[i].size(); k++) if (mq[i][k].cf) ncf++;
    space = (mq[i].size() < dep(i)) || m_pop(i);
    cfok  = (cfl(i) == 0) || !cf_in || (ncf < cfl(i)) || (m_pop(i) && mq[i][0].cf);
    return space && cfok;
  endfunction

  task automatic drive(input bit v, input bit c, input bit a, input bit f);
    logic [63:0] r;
    seq++;
    r      = {$urandom, $urandom};
    din    = r[55:0];
    din.pc = 32'(seq);
    valid  = v;
    cf_in  = c;
    ack    = a;
    flush  = f;
    #1;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      tb_check($sformatf("u%0d_ready", i), 64'(rdy[i]), 64'(m_ready(i)));
      tb_check($sformatf("u%0d_valid", i), 64'(vld[i]), 64'(mq[i].size() != 0));
      tb_check($sformatf("u%0d_usage", i), usage_of(i), 64'(mq[i].size()));
      tb_check($sformatf("u%0d_cf_out", i), 64'(cfo[i]),
               64'((mq[i].size() != 0) ? mq[i][0].cf : 1'b0));
      if (mq[i].size() != 0)
        tb_check($sformatf("u%0d_head", i), 64'(head[i]), 64'(mq[i][0].e));
    end
  endtask

  task automatic tick();
    bit pu [N];
    bit po [N];
    for (int i = 0; i < N; i++) begin
      po[i] = m_pop(i);
      pu[i] = valid && m_ready(i) && !flush;
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst_n || flush) begin
        mq[i].delete();
      end else begin
        if (po[i]) void'(mq[i].pop_front());
        if (pu[i]) mq[i].push_back('{cf: cf_in, e: din});
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit v, input bit c, input bit a, input bit f);
    drive(v, c, a, f);
    check_all();
    tick();
  endtask

  scoreboard_entry_t ent_a, ent_b, ent_h;

  initial begin
    // Reset state
    @(negedge clk);
    drive(0, 0, 0, 0);
    check_all();
    tb_check("reset_usage", usage_of(0), 64'd0);
    tick();
    rst_n = 1'b1;

    // Ack while empty is ignored
    step(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    check_all();
    tb_check("empty_ack_usage", usage_of(0), 64'd0);
    tick();

    // Fill DEPTH=4 with A..D, then ack + push on a full queue
    drive(1, 0, 0, 0); ent_a = din; check_all(); tick();
    drive(1, 0, 0, 0); ent_b = din; check_all(); tick();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_all();
    tb_check("full_usage", usage_of(0), 64'd4);
    tb_check("full_ready", 64'(rdy[0]), 64'd0);
    tb_check("full_head_a", 64'(head[0]), 64'(ent_a));
    drive(1, 0, 1, 0);
    check_all();
    tb_check("full_ack_ready", 64'(rdy[0]), 64'd1);
    tick();
    drive(0, 0, 0, 0);
    check_all();
    tb_check("full_ack_usage", usage_of(0), 64'd4);
    tb_check("full_ack_head_b", 64'(head[0]), 64'(ent_b));

    // Drop to three entries, then flush with a push pending
    step(0, 0, 1, 0);
    step(1, 0, 0, 1);
    drive(0, 0, 0, 0);
    check_all();
    tb_check("flush_usage", usage_of(0), 64'd0);
    tb_check("flush_valid", 64'(vld[0]), 64'd0);
    tick();

    // Second branch stalls until the branch at the head is acked
    step(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    check_all();
    tb_check("cf_stall", 64'(rdy[1]), 64'd0);
    tick();
    drive(1, 1, 1, 0);
    ent_h = din;
    check_all();
    tb_check("cf_accept_on_ack", 64'(rdy[1]), 64'd1);
    tick();
    drive(0, 0, 0, 0);
    check_all();
    tb_check("cf_head_second", 64'(head[1]), 64'(ent_h));
    tick();
    step(0, 0, 0, 1);

    // Wrap-around: ten push/pop pairs behind one held entry
    step(1, 0, 0, 0);
    for (int n = 0; n < 10; n++) step(1, 0, 1, 0);
    step(0, 0, 1, 0);

    // Asynchronous reset with two entries held
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) mq[i].delete();
    check_all();
    tb_check("async_rst_valid", 64'(vld[0]), 64'd0);
    tb_check("async_rst_cf", 64'(cfo[1]), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(1, 0, 0, 0);
    ent_a = din;
    check_all();
    tick();
    drive(0, 0, 0, 0);
    check_all();
    tb_check("post_rst_head", 64'(head[0]), 64'(ent_a));
    tb_check("post_rst_usage", usage_of(0), 64'd1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 SHALL have parameter DEPTH, default 2, number of decoded-instruction slots (legal: 1..16).
REQ-003 SHALL have parameter CF_LIMIT, default 0, maximum control-flow entries held at once (0 = unlimited).
REQ-004 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  in  1  discard all held entries.
REQ-007 SHALL have port decoded_i  in  ariane_pkg::scoreboard_entry_t  decoded instruction from decoder.
REQ-008 SHALL have port is_ctrl_flow_i  in  1  decoded instruction is control flow.
REQ-009 SHALL have port valid_i  in  1  decoded_i/is_ctrl_flow_i valid.
REQ-010 SHALL have port ready_o  out  1  entry accepted this cycle when valid_i && ready_o (fetch acknowledge).
REQ-011 SHALL have port issue_entry_o  out  ariane_pkg::scoreboard_entry_t  head entry.
REQ-012 SHALL have port issue_entry_valid_o  out  1  head entry valid.
REQ-013 SHALL have port is_ctrl_flow_o  out  1  head entry is control flow.
REQ-014 SHALL have port issue_instr_ack_i  in  1  issue stage consumes head this cycle.
REQ-015 SHALL have port usage_o  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL store entries in a circular buffer of DEPTH slots with read/write pointers (width max(1,$clog2(DEPTH))) wrapping DEPTH-1 -> 0, and a count 0..DEPTH.
REQ-017 SHALL drive issue_entry_o/is_ctrl_flow_o from the slot at the read pointer and issue_entry_valid_o = (count != 0); all outputs come from registers, no combinational path from decoded_i.
REQ-018 SHALL expose an accepted entry at the head no earlier than the cycle after acceptance (latency 1 when empty).
REQ-019 SHALL compute pop = issue_instr_ack_i && count != 0; ack while empty SHALL be ignored.
REQ-020 SHALL compute space_ok = (count < DEPTH) || pop, i.e. full queue accepts when head is acked same cycle.
REQ-021 SHALL, when CF_LIMIT != 0, compute cf_ok = !is_ctrl_flow_i || (cf_count < CF_LIMIT) || (pop && is_ctrl_flow_o); otherwise cf_ok = 1.
REQ-022 SHALL drive ready_o = space_ok && cf_ok (independent of valid_i apart from the is_ctrl_flow_i qualifier).
REQ-023 SHALL maintain cf_count (0..DEPTH) = number of held control-flow entries, updated by push and pop in the same cycle.
REQ-024 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-025 SHALL on flush_i set count, cf_count and both pointers to 0 next cycle; ready_o follows REQ-022 during flush and any entry accepted that cycle is dropped.
REQ-026 SHALL preserve order: entries leave in acceptance order, none duplicated or lost except on flush.
REQ-027 SHALL with DEPTH=1, CF_LIMIT=0 be cycle-identical to a single ID/issue pipeline register.

Reset
REQ-028 SHALL on rst_ni low clear count, cf_count and pointers asynchronously: issue_entry_valid_o=0, usage_o=0, is_ctrl_flow_o=0.
REQ-029 SHALL not require reset of slot payload; issue_entry_o is don't-care while issue_entry_valid_o=0.
REQ-030 SHALL on reset asserted mid-operation discard all entries; first accept after release appears at head one cycle later.

Structure
REQ-031 SHALL place any per-slot struct (scoreboard entry plus ctrl-flow bit) in ariane_pkg; DEPTH and CF_LIMIT remain module parameters.
REQ-032 SHALL be implemented as a single module without sub-modules; storage and pointer logic inline.

Verification
REQ-033 SHALL cover: DEPTH=4, push 4 entries A..D with no ack -> usage_o=4, ready_o=0, head=A; then ack+push E same cycle -> ready_o=1, usage_o stays 4, head=B.
REQ-034 SHALL cover: DEPTH=4, CF_LIMIT=1, push branch then push second branch -> second stalls (ready_o=0) until branch head acked, accepted same cycle as ack.
REQ-035 SHALL cover: DEPTH=4, 3 entries held, flush_i with valid_i=1 -> next cycle usage_o=0, issue_entry_valid_o=0, flushed-cycle entry absent.
REQ-036 SHALL cover: wrap-around, 10 push/pop pairs at DEPTH=4 -> entries issued in order, pointers wrap, usage_o never exceeds 4.
REQ-037 SHALL cover: ack while empty -> no state change, usage_o=0; DEPTH=1 run matches single-register model cycle-for-cycle.
REQ-038 SHALL cover: rst_ni asserted with 2 entries held -> outputs cleared immediately, no entry reappears after release.
